// File: rtl/anf_fl_tex_mem_arb_pkg.sv
// Shared definitions for the texture memory read path: packet width,
// memory read port widths and the requester ID width helper.
package anfFl_tex_pkg;

   localparam int TEX_PKT_W  = 128;
   localparam int TEX_ADDR_W = 32;
   localparam int TEX_DATA_W = TEX_PKT_W;

   // A single requester still needs one ID bit so the tag FIFO has a real width.
   function automatic int req_id_w(input int num_req);
      return (num_req <= 1) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/anf_fl_tex_mem_arb_tag_fifo.sv
// In-order tag FIFO holding requester IDs of reads in flight; push and pop
// may happen in the same cycle, occupancy is exposed as a registered count.
module anf_fl_tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int             PTR_W     = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign full     = (count == DEPTH_CNT);
   assign empty    = (count == '0);
   assign pop_data = store[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/anf_fl_tex_mem_arb.sv
// Round-robin arbiter sharing the texture memory read port between the
// colour packet fetchers; in-order responses are routed back by tag.
module anf_fl_tex_mem_arb
   import anfFl_tex_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = TEX_ADDR_W,
   parameter int DATA_W  = TEX_DATA_W,
   parameter int MAX_OUT = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        mem_rd_valid,
   input  logic                        mem_rd_ready,
   output logic [ADDR_W-1:0]           mem_rd_addr,
   input  logic                        mem_rsp_valid,
   output logic                        mem_rsp_ready,
   input  logic [DATA_W-1:0]           mem_rsp_data,
   output logic [$clog2(MAX_OUT):0]    outstanding,
   output logic                        err_orphan
);

   localparam int                ID_W        = req_id_w(NUM_REQ);
   localparam logic [ID_W:0]     NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0]   LAST_ID     = ID_W'(NUM_REQ-1);

   logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
   logic [NUM_REQ-1:0] eligible;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    head_id;
   logic [ID_W:0]      scan;
   logic               found;
   logic               issue;
   logic               rsp_fire;
   logic               fifo_full;
   logic               fifo_empty;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
      assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
   end

   // Scan from rr_ptr upward with wrap; the full check uses registered occupancy,
   // and reset is folded in so every request-side output drops immediately.
   always_comb begin
      eligible = req_valid & {NUM_REQ{~fifo_full & ~reset}};
      winner   = '0;
      found    = 1'b0;
      scan     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (scan >= NUM_REQ_EXT) scan = scan - NUM_REQ_EXT;
         if (!found && eligible[scan[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = scan[ID_W-1:0];
         end
      end
   end

   assign mem_rd_valid = found;
   assign mem_rd_addr  = addr_arr[winner];
   assign issue        = mem_rd_valid & mem_rd_ready;
   assign rsp_data     = mem_rsp_data;

   always_comb begin
      req_ready = '0;
      if (issue) req_ready[winner] = 1'b1;
   end

   // With nothing outstanding a memory beat is an orphan: swallow it so memory
   // cannot wedge, and show it to no requester.
   always_comb begin
      rsp_valid     = '0;
      rsp_fire      = 1'b0;
      mem_rsp_ready = 1'b0;
      if (!reset) begin
         if (fifo_empty) begin
            mem_rsp_ready = mem_rsp_valid;
         end else begin
            mem_rsp_ready      = rsp_ready[head_id];
            rsp_valid[head_id] = mem_rsp_valid;
            rsp_fire           = mem_rsp_valid & rsp_ready[head_id];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr     <= '0;
         err_orphan <= 1'b0;
      end else begin
         if (issue) rr_ptr <= (winner == LAST_ID) ? '0 : winner + 1'b1;
         if (mem_rsp_valid && fifo_empty) err_orphan <= 1'b1;
      end
   end

   anf_fl_tag_fifo #(
      .WIDTH (ID_W),
      .DEPTH (MAX_OUT)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (issue),
      .push_data (winner),
      .pop       (rsp_fire),
      .pop_data  (head_id),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (outstanding)
   );

endmodule

// File: tb/tb_anf_fl_tex_mem_arb.sv
// Randomised bench for the texture memory arbiter: a queue-based reference of
// reads in flight predicts grants and routing, a monitor scores every cycle.
module tb_anf_fl_tex_mem_arb;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 128;
   localparam int MAX_OUT = 4;
   localparam int ID_W    = $clog2(NUM_REQ);
   localparam int CNT_W   = $clog2(MAX_OUT) + 1;

   typedef struct packed {
      logic [7:0]        id;
      logic [DATA_W-1:0] data;
   } exp_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      int                due;
   } mem_t;

   logic                      clk;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]         rsp_data;
   logic                      mem_rd_valid;
   logic                      mem_rd_ready;
   logic [ADDR_W-1:0]         mem_rd_addr;
   logic                      mem_rsp_valid;
   logic                      mem_rsp_ready;
   logic [DATA_W-1:0]         mem_rsp_data;
   logic [CNT_W-1:0]          outstanding;
   logic                      err_orphan;

   logic [ADDR_W-1:0] reqAddr [NUM_REQ];

   exp_t sbQ[$];
   mem_t memQ[$];
   int   compared     = 0;
   int   mismatched   = 0;
   int   rrModel      = 0;
   bit   errModel     = 0;
   int   issueSerial  = 0;
   int   memSerial    = 0;
   int   cyc          = 0;

   bit   autoReq      = 0;
   int   reqProb      = 100;
   int   rdReadyProb  = 100;
   int   rspProb      = 100;
   int   latMin       = 2;
   int   latSpread    = 0;
   bit   memHold      = 0;
   bit   orphanPulse  = 0;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
      assign req_addr[g*ADDR_W +: ADDR_W] = reqAddr[g];
   end

   anf_fl_tex_mem_arb #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .mem_rd_valid  (mem_rd_valid),
      .mem_rd_ready  (mem_rd_ready),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_ready (mem_rsp_ready),
      .mem_rsp_data  (mem_rsp_data),
      .outstanding   (outstanding),
      .err_orphan    (err_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents are a pure function of address and read sequence number.
   function automatic logic [DATA_W-1:0] mkData(input logic [ADDR_W-1:0] a, input int s);
      logic [31:0] sv;
      sv = s;
      return {a, sv, ~a, sv ^ 32'hA5A5_0000};
   endfunction

   task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                              input logic [DATA_W-1:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Reference: a queue of reads in flight, a round-robin start index and a sticky error bit.
   always @(negedge clk) begin : monitor
      logic [NUM_REQ-1:0] elig;
      logic [NUM_REQ-1:0] expReady;
      logic [NUM_REQ-1:0] expRspValid;
      int                 win;
      int                 idx;
      bit                 popOk;
      exp_t               head;
      if (reset) begin
         checkOutput("reset_mem_rd_valid", mem_rd_valid, 0);
         checkOutput("reset_req_ready", req_ready, 0);
         checkOutput("reset_rsp_valid", rsp_valid, 0);
         checkOutput("reset_outstanding", outstanding, 0);
         checkOutput("reset_err_orphan", err_orphan, 0);
         sbQ.delete();
         rrModel     = 0;
         errModel    = 0;
         issueSerial = 0;
      end else begin
         checkOutput("outstanding", outstanding, sbQ.size());
         checkOutput("err_orphan", err_orphan, errModel);
         elig = (sbQ.size() < MAX_OUT) ? req_valid : '0;
         win  = -1;
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (rrModel + k) % NUM_REQ;
            if (win < 0 && elig[ID_W'(idx)]) win = idx;
         end
         checkOutput("mem_rd_valid", mem_rd_valid, win >= 0);
         expReady = '0;
         if (win >= 0) begin
            checkOutput("mem_rd_addr", mem_rd_addr, reqAddr[ID_W'(win)]);
            if (mem_rd_ready) expReady[ID_W'(win)] = 1'b1;
         end
         checkOutput("req_ready", req_ready, expReady);

         expRspValid = '0;
         popOk       = 0;
         if (mem_rsp_valid) begin
            if (sbQ.size() == 0) begin
               checkOutput("orphan_mem_rsp_ready", mem_rsp_ready, 1);
               errModel = 1;
            end else begin
               expRspValid[ID_W'(sbQ[0].id)] = 1'b1;
               checkOutput("mem_rsp_ready", mem_rsp_ready, rsp_ready[ID_W'(sbQ[0].id)]);
               popOk = rsp_ready[ID_W'(sbQ[0].id)];
            end
         end
         checkOutput("rsp_valid", rsp_valid, expRspValid);

         if (|(rsp_valid & rsp_ready)) begin
            if (sbQ.size() == 0) begin
               checkOutput("rsp_unexpected", rsp_valid & rsp_ready, 0);
            end else begin
               head = sbQ.pop_front();
               checkOutput("rsp_route", rsp_valid, 1 << head.id);
               checkOutput("rsp_data", rsp_data, head.data);
            end
         end else if (popOk) begin
            sbQ.delete(0);
         end

         if (win >= 0 && mem_rd_ready) begin
            sbQ.push_back(exp_t'{id: 8'(win), data: mkData(reqAddr[ID_W'(win)], issueSerial)});
            issueSerial++;
            rrModel = (win + 1) % NUM_REQ;
         end
      end
   end

   // One cycle of requesters plus in-order memory: sample handshakes, then drive after the edge.
   task automatic applyStimulus();
      logic [NUM_REQ-1:0] acc;
      logic               rspAcc;
      @(negedge clk);
      acc    = req_ready;
      rspAcc = mem_rsp_valid && mem_rsp_ready;
      if (reset) begin
         memQ.delete();
         memSerial = 0;
      end else begin
         if (rspAcc && memQ.size() > 0) memQ.delete(0);
         if (mem_rd_valid && mem_rd_ready) begin
            memQ.push_back(mem_t'{data: mkData(mem_rd_addr, memSerial),
                                  due: cyc + latMin + int'($urandom_range(latSpread))});
            memSerial++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (acc[i]) req_valid[i] = 1'b0;
         if (!req_valid[i] && autoReq && int'($urandom_range(99)) < reqProb) begin
            req_valid[i] = 1'b1;
            reqAddr[i]   = $urandom & 32'hFFFF_FFF0;
         end
         rsp_ready[i] = (int'($urandom_range(99)) < rspProb);
      end
      mem_rd_ready = (int'($urandom_range(99)) < rdReadyProb);
      if (orphanPulse) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
         orphanPulse   = 0;
      end else if (!memHold && memQ.size() > 0 && cyc >= memQ[0].due) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = memQ[0].data;
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      req_valid     = '0;
      rsp_ready     = '1;
      mem_rd_ready  = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) reqAddr[i] = '0;
      repeat (2) applyStimulus();
      reset = 1'b0;

      $display("[TB] single request from requester 2");
      autoReq      = 0;
      req_valid    = 4'b0100;
      reqAddr[2]   = 32'h0000_1000;
      repeat (6) applyStimulus();

      $display("[TB] all requesters streaming");
      autoReq = 1;
      reqProb = 100;
      repeat (40) applyStimulus();

      $display("[TB] memory responses held off");
      memHold = 1;
      repeat (6) applyStimulus();
      memHold = 0;
      repeat (10) applyStimulus();

      $display("[TB] requesters backpressure responses");
      rspProb = 0;
      repeat (3) applyStimulus();
      rspProb = 100;
      repeat (6) applyStimulus();

      $display("[TB] random traffic");
      reqProb     = 40;
      rdReadyProb = 70;
      rspProb     = 70;
      latMin      = 1;
      latSpread   = 3;
      repeat (400) applyStimulus();

      $display("[TB] draining");
      autoReq     = 0;
      rdReadyProb = 100;
      rspProb     = 100;
      for (int k = 0; k < 200 && (sbQ.size() != 0 || req_valid != '0); k++) applyStimulus();
      checkOutput("drain_outstanding", outstanding, 0);

      $display("[TB] orphan memory response");
      orphanPulse = 1;
      repeat (5) applyStimulus();
      checkOutput("err_orphan_sticky", err_orphan, 1);

      $display("[TB] asynchronous reset with reads in flight");
      autoReq = 1;
      reqProb = 100;
      latMin  = 2;
      memHold = 1;
      for (int k = 0; k < 20 && sbQ.size() < 3; k++) applyStimulus();
      checkOutput("pre_reset_outstanding", outstanding, 3);
      #2;
      reset         = 1'b1;
      mem_rsp_valid = 1'b0;
      #1;
      checkOutput("async_outstanding", outstanding, 0);
      checkOutput("async_req_ready", req_ready, 0);
      checkOutput("async_rsp_valid", rsp_valid, 0);
      checkOutput("async_mem_rd_valid", mem_rd_valid, 0);
      checkOutput("async_err_orphan", err_orphan, 0);
      repeat (2) applyStimulus();
      reset   = 1'b0;
      memHold = 0;
      #1;
      checkOutput("first_grant_after_reset", req_ready, mem_rd_ready ? 4'b0001 : 4'b0000);
      repeat (20) applyStimulus();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
